node_acc_n: RTL

- Parametrised neuron accumulator for the node function datapath. Successor to the fixed 22-bit bias-plus-accumulate block.
- Takes a stream of signed DIN_W-bit products, N_TERMS per neuron. Adds the neuron's signed bias once per neuron.
- Emits one result per neuron with optional output saturation and optional ReLU.
- Sits between the product multiplier and the activation/output buffer. Sequencing is internal via a term counter; no separate ctrl module is needed.

---
 rtl/node_pkg.sv | 29 ++
 rtl/node_acc_n_if.sv | 30 +++
 rtl/node_sat_relu.sv | 35 +++
 rtl/node_acc_n.sv | 98 +++++++++
 4 files changed

// File: rtl/node_pkg.sv
// Shared definitions for the node-function datapath blocks: default widths,
// internal sum sizing and a generic signed saturate/clip helper.
package node_pkg;

  localparam int DEF_DIN_W = 20;
  localparam int DEF_B_W   = 8;
  localparam int DEF_ACC_W = 22;

  // Wide enough for n_terms products plus a bias no wider than one product.
  function automatic int sum_w(input int din_w, input int n_terms);
    return din_w + $clog2(n_terms) + 1;
  endfunction

  // Clamp a signed value into the representable range of a signed 'width'-bit word.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/node_acc_n_if.sv
// Term-stream input and neuron-result output bundle of the node accumulator.
interface node_acc_n_if
  import node_pkg::*;
#(
  parameter int DIN_W = DEF_DIN_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W
) ();

  logic                    clear;
  logic                    relu_en;
  logic                    in_valid;
  logic signed [DIN_W-1:0] din;
  logic signed [B_W-1:0]   b;
  logic                    out_valid;
  logic signed [ACC_W-1:0] dout;
  logic                    sat;
  logic                    busy;

  modport master (
    output clear, relu_en, in_valid, din, b,
    input  out_valid, dout, sat, busy
  );

  modport slave (
    input  clear, relu_en, in_valid, din, b,
    output out_valid, dout, sat, busy
  );

endinterface

// File: rtl/node_sat_relu.sv
// Combinational post-processing of a full-width neuron sum: optional saturation
// (or wrap) to ACC_W, then optional ReLU. The sat flag reflects the pre-ReLU value.
module node_sat_relu
  import node_pkg::*;
#(
  parameter int SUM_W  = 23,
  parameter int ACC_W  = DEF_ACC_W,
  parameter bit SAT_EN = 1'b1
) (
  input  logic signed [SUM_W-1:0] sum_i,
  input  logic                    relu_en_i,
  output logic signed [ACC_W-1:0] res_o,
  output logic                    sat_o
);

  logic signed [63:0]      wide;
  logic signed [ACC_W-1:0] clipped;

  assign wide = 64'(sum_i);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    clipped = ACC_W'(wide);
    sat_o   = 1'b0;
    if (SAT_EN) begin
      clipped = ACC_W'(sat_trunc(wide, ACC_W));
      sat_o   = (wide != sat_trunc(wide, ACC_W));
    end
    res_o = clipped;
    if (relu_en_i && clipped[ACC_W-1]) begin
      res_o = '0;
    end
  end

endmodule

// File: rtl/node_acc_n.sv
// Neuron accumulator: bias + N_TERMS signed products per neuron, sequenced by an
// internal term counter, with a registered result and one-cycle out_valid pulse.
module node_acc_n
  import node_pkg::*;
#(
  parameter int DIN_W   = DEF_DIN_W,
  parameter int B_W     = DEF_B_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int N_TERMS = 4,
  parameter bit SAT_EN  = 1'b1
) (
  input logic         clk,
  input logic         rst,
  node_acc_n_if.slave bus
);

  localparam int SUM_W = sum_w(DIN_W, N_TERMS);
  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] dout_q, dout_d;
  logic                    sat_q, sat_d;
  logic                    out_valid_q, out_valid_d;

  logic                    is_first;
  logic                    is_last;
  logic signed [SUM_W-1:0] b_ext;
  logic signed [SUM_W-1:0] din_ext;
  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] post_res;
  logic                    post_sat;

  assign is_first = (cnt_q == '0);
  assign is_last  = (cnt_q == CNT_W'(N_TERMS - 1));
  assign b_ext    = SUM_W'(bus.b);
  assign din_ext  = SUM_W'(bus.din);

  // With N_TERMS == 1 the first term is also the last, so the bias joins here too.
  assign sum = (is_first ? b_ext : acc_q) + din_ext;

  node_sat_relu #(
    .SUM_W (SUM_W),
    .ACC_W (ACC_W),
    .SAT_EN(SAT_EN)
  ) u_sat_relu (
    .sum_i    (sum),
    .relu_en_i(bus.relu_en),
    .res_o    (post_res),
    .sat_o    (post_sat)
  );

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    if (bus.clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (bus.in_valid) begin
      if (is_last) begin
        cnt_d       = '0;
        acc_d       = '0;
        dout_d      = post_res;
        sat_d       = post_sat;
        out_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = sum;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.sat       = sat_q;
  assign bus.busy      = (cnt_q != '0);

endmodule
